// File: rtl/xnor_popcount_stream.sv
// xnor_popcount_stream: multi-channel streaming XNOR-popcount accumulator with per-frame threshold compare
// Ports: clk/rstn (async active-low); in_valid/in_ready/in_first/in_last with xi (activation),
// wi (CH weight chunks, channel c at [c*N +: N]) and ti (CH thresholds, sampled on the last beat);
// out_valid/out_ready with out_bit (sum > threshold), out_sum (saturated sums) and out_sat per channel.
module xnor_popcount_stream #(
  parameter int N     = 256,
  parameter int CH    = 4,
  parameter int ACC_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [N-1:0]        xi,
  input  logic [N*CH-1:0]     wi,
  input  logic [ACC_W*CH-1:0] ti,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH-1:0]       out_bit,
  output logic [ACC_W*CH-1:0] out_sum,
  output logic [CH-1:0]       out_sat
);
  localparam int PW = $clog2(N) + 1;
  logic                         p_valid_q, p_valid_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic [ACC_W*CH-1:0]          p_ti_q, p_ti_d;
  logic [CH-1:0][PW-1:0]        p_pop_q, p_pop_d, pop;
  logic [CH-1:0][ACC_W-1:0]     acc_q, acc_d, nxt;
  logic [CH-1:0][ACC_W:0]       wide;
  logic [CH-1:0]                sat_q, sat_d, sat_nxt;
  logic                         out_valid_q, out_valid_d;
  logic [CH-1:0]                out_bit_q, out_bit_d, out_sat_q, out_sat_d;
  logic [ACC_W*CH-1:0]          out_sum_q, out_sum_d;
  logic                         a_adv, accept, load;

  // A last beat may only retire into the output registers once they are free or being handed off.
  assign a_adv    = p_valid_q && !(p_last_q && out_valid_q && !out_ready);
  assign in_ready = !p_valid_q || a_adv;
  assign accept   = in_valid && in_ready;
  assign load     = a_adv && p_last_q;

  always_comb begin
    pop = '0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < N; i++)
        pop[c] = pop[c] + PW'(~(xi[i] ^ wi[c*N+i]));
    p_valid_d = accept || (p_valid_q && !a_adv);
    p_first_d = accept ? in_first : p_first_q;
    p_last_d  = accept ? in_last : p_last_q;
    p_ti_d    = accept ? ti : p_ti_q;
    p_pop_d   = accept ? pop : p_pop_q;
  end

  // The accumulator is one bit wider during the add so overflow is visible as the carry-out.
  always_comb begin
    wide      = '0;
    nxt       = '0;
    sat_nxt   = '0;
    out_bit_d = out_bit_q;
    for (int c = 0; c < CH; c++) begin
      wide[c]      = (ACC_W+1)'(p_first_q ? ACC_W'(0) : acc_q[c]) + (ACC_W+1)'(p_pop_q[c]);
      nxt[c]       = wide[c][ACC_W] ? {ACC_W{1'b1}} : wide[c][ACC_W-1:0];
      sat_nxt[c]   = wide[c][ACC_W] || (!p_first_q && sat_q[c]);
      out_bit_d[c] = load ? (nxt[c] > p_ti_q[c*ACC_W +: ACC_W]) : out_bit_q[c];
    end
    acc_d       = a_adv ? (p_last_q ? '0 : nxt) : acc_q;
    sat_d       = a_adv ? (p_last_q ? '0 : sat_nxt) : sat_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    out_sum_d   = load ? nxt : out_sum_q;
    out_sat_d   = load ? sat_nxt : out_sat_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_ti_q      <= '0;
      p_pop_q     <= '0;
      acc_q       <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= '0;
      out_sum_q   <= '0;
      out_sat_q   <= '0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      p_ti_q      <= p_ti_d;
      p_pop_q     <= p_pop_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_xnor_popcount_stream.sv
// tb_xnor_popcount_stream: directed table, stall/reset sequences and random frames against a reference model
module tb_xnor_popcount_stream;
  localparam int N = 256, CH = 4, W1 = 16, W2 = 10;
  logic clk = 0, rstn = 0, in_valid = 0, in_first = 0, in_last = 0, out_ready = 1;
  logic [N-1:0] xi = '0;
  logic [N*CH-1:0] wi = '0;
  logic [W1*CH-1:0] ti = '0;
  logic [W2*CH-1:0] ti10;
  logic in_ready, in_ready10, out_valid, out_valid10;
  logic [CH-1:0] out_bit, out_sat, out_bit10, out_sat10;
  logic [W1*CH-1:0] out_sum;
  logic [W2*CH-1:0] out_sum10;

  always #5 clk = ~clk;
  always_comb for (int c = 0; c < CH; c++) ti10[c*W2 +: W2] = ti[c*W1 +: W2];

  xnor_popcount_stream #(.N(N), .CH(CH), .ACC_W(W1)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_last(in_last), .xi(xi), .wi(wi), .ti(ti), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_sum(out_sum), .out_sat(out_sat));
  xnor_popcount_stream #(.N(N), .CH(CH), .ACC_W(W2)) u_dut10 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready10), .in_first(in_first),
    .in_last(in_last), .xi(xi), .wi(wi), .ti(ti10), .out_valid(out_valid10), .out_ready(out_ready),
    .out_bit(out_bit10), .out_sum(out_sum10), .out_sat(out_sat10));

  typedef struct {
    logic [W1*CH-1:0] sum;
    logic [CH-1:0] bits, sat;
    logic [W2*CH-1:0] sum10;
    logic [CH-1:0] bits10, sat10;
  } res_t;
  typedef struct {
    int nb;
    logic [N-1:0] x;
    logic [N*CH-1:0] w;
    logic [W1*CH-1:0] t;
    logic [W1*CH-1:0] e_sum;
    logic [CH-1:0] e_bit, e_sat;
    logic [W2*CH-1:0] e_sum10;
    logic [CH-1:0] e_sat10;
  } vec_t;

  res_t exp_q[$];
  vec_t tbl[7];
  int msum[2][CH];
  bit msat[2][CH];
  int n_cmp = 0, n_bad = 0;
  bit rand_mode = 0;
  logic [N-1:0] ones, xa, w100, rx;
  logic [N*CH-1:0] ones4, wmix, rw;
  logic [W1*CH-1:0] rt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) begin
        msum[i][c] = 0;
        msat[i][c] = 0;
      end
    exp_q.delete();
  endfunction

  function automatic void model_accept(input logic [N-1:0] x, input logic [N*CH-1:0] w,
                                       input logic [W1*CH-1:0] t, input logic f, input logic l);
    res_t r;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) begin
        int mx;
        mx = (i == 0) ? 65535 : 1023;
        if (f) begin
          msum[i][c] = 0;
          msat[i][c] = 0;
        end
        msum[i][c] += $countones(~(x ^ w[c*N +: N]));
        if (msum[i][c] > mx) begin
          msum[i][c] = mx;
          msat[i][c] = 1;
        end
      end
    if (l) begin
      for (int c = 0; c < CH; c++) begin
        r.sum[c*W1 +: W1]   = W1'(msum[0][c]);
        r.bits[c]           = msum[0][c] > int'(t[c*W1 +: W1]);
        r.sat[c]            = msat[0][c];
        r.sum10[c*W2 +: W2] = W2'(msum[1][c]);
        r.bits10[c]         = msum[1][c] > int'(t[c*W1 +: W2]);
        r.sat10[c]          = msat[1][c];
      end
      exp_q.push_back(r);
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < CH; c++) begin
          msum[i][c] = 0;
          msat[i][c] = 0;
        end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom % 3) != 0;
  endtask

  task automatic beat(input logic [N-1:0] x, input logic [N*CH-1:0] w, input logic [W1*CH-1:0] t,
                      input logic f, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1; xi = x; wi = w; ti = t; in_first = f; in_last = l;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) model_accept(x, w, t, f, l);
    end
    in_valid = 0; in_first = 0; in_last = 0;
    chk("beat_accept", 64'(ok), 64'(1));
  endtask

  initial begin
    ones  = '1;
    ones4 = '1;
    xa    = {128{2'b10}};
    wmix  = {xa, xa ^ {{128{1'b1}}, {128{1'b0}}}, ~xa, xa};
    w100  = '0;
    w100[99:0] = '1;
    tbl[0] = '{1, ones, ones4, {4{16'd255}}, {4{16'd256}}, 4'b1111, 4'b0000, {4{10'd256}}, 4'b0000};
    tbl[1] = '{4, xa, wmix, {16'd1024, 16'd0, 16'd511, 16'd1023},
               {16'd1024, 16'd512, 16'd0, 16'd1024}, 4'b0101, 4'b0000,
               {10'd1023, 10'd512, 10'd0, 10'd1023}, 4'b1001};
    tbl[2] = '{4, ones, ones4, '0, {4{16'd1024}}, 4'b1111, 4'b0000, {4{10'd1023}}, 4'b1111};
    tbl[3] = '{1, ones, ones4, {4{16'd255}}, {4{16'd256}}, 4'b1111, 4'b0000, {4{10'd256}}, 4'b0000};
    tbl[4] = '{2, ones, '0, '0, '0, 4'b0000, 4'b0000, '0, 4'b0000};
    tbl[5] = '{8, ones, ones4, {4{16'd2047}}, {4{16'd2048}}, 4'b1111, 4'b0000, {4{10'd1023}}, 4'b1111};
    tbl[6] = '{8, ones, ones4, {4{16'd2048}}, {4{16'd2048}}, 4'b0000, 4'b0000, {4{10'd1023}}, 4'b1111};
    model_reset();
    fork
      forever begin
        res_t r;
        @(negedge clk);
        if (rstn && out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
          else begin
            r = exp_q.pop_front();
            chk("mon_sum", out_sum, r.sum);
            chk("mon_bit", 64'(out_bit), 64'(r.bits));
            chk("mon_sat", 64'(out_sat), 64'(r.sat));
            chk("mon_valid10", 64'(out_valid10), 64'(1));
            chk("mon_sum10", 64'(out_sum10), 64'(r.sum10));
            chk("mon_bit10", 64'(out_bit10), 64'(r.bits10));
            chk("mon_sat10", 64'(out_sat10), 64'(r.sat10));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_ready", 64'(in_ready), 64'(1));
    chk("reset_sum", out_sum, 64'(0));
    chk("reset_bit", 64'(out_bit), 64'(0));
    chk("reset_sat", 64'(out_sat), 64'(0));
    @(posedge clk);
    #1 rstn = 1;

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < tbl[i].nb; b++)
        beat(tbl[i].x, tbl[i].w, tbl[i].t, b == 0, b == tbl[i].nb - 1);
      @(negedge clk);
      chk($sformatf("tbl%0d_lat_early", i), 64'(out_valid), 64'(0));
      @(negedge clk);
      chk($sformatf("tbl%0d_lat", i), 64'(out_valid), 64'(1));
      chk($sformatf("tbl%0d_sum", i), out_sum, tbl[i].e_sum);
      chk($sformatf("tbl%0d_bit", i), 64'(out_bit), 64'(tbl[i].e_bit));
      chk($sformatf("tbl%0d_sat", i), 64'(out_sat), 64'(tbl[i].e_sat));
      chk($sformatf("tbl%0d_sum10", i), 64'(out_sum10), 64'(tbl[i].e_sum10));
      chk($sformatf("tbl%0d_sat10", i), 64'(out_sat10), 64'(tbl[i].e_sat10));
      tick();
    end

    out_ready = 0;
    beat(ones, ones4, {4{16'd255}}, 1, 1);
    for (int b = 0; b < 3; b++) beat(xa, wmix, {4{16'd300}}, b == 0, b == 2);
    in_valid = 1; xi = ones; wi = ones4; ti = {4{16'd100}}; in_first = 1; in_last = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_ready", 64'(in_ready), 64'(0));
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_sum", out_sum, {4{16'd256}});
      tick();
    end
    out_ready = 1;
    @(negedge clk);
    chk("unstall_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    model_accept(ones, ones4, {4{16'd100}}, 1, 1);
    #1 in_valid = 0; in_first = 0; in_last = 0;
    @(negedge clk);
    chk("b2b_valid1", 64'(out_valid), 64'(1));
    @(negedge clk);
    chk("b2b_valid2", 64'(out_valid), 64'(1));
    tick();

    beat(ones, ones4, {4{16'd255}}, 1, 0);
    beat(ones, ones4, {4{16'd255}}, 0, 0);
    rstn = 0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(1));
    chk("midrst_sum", out_sum, 64'(0));
    chk("midrst_bit", 64'(out_bit), 64'(0));
    model_reset();
    @(posedge clk);
    #1 rstn = 1;
    beat(ones, {4{w100}}, {4{16'd99}}, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("postrst_valid", 64'(out_valid), 64'(1));
    chk("postrst_sum", out_sum, {4{16'd100}});
    chk("postrst_bit", 64'(out_bit), 64'(4'b1111));
    chk("postrst_sum10", 64'(out_sum10), 64'({4{10'd100}}));
    tick();

    rand_mode = 1;
    for (int f = 0; f < 150; f++) begin
      int nb;
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < N / 32; k++) rx[k*32 +: 32] = $urandom;
        for (int c = 0; c < CH; c++) begin
          int m;
          m = $urandom % 4;
          for (int k = 0; k < N / 32; k++) rw[c*N + k*32 +: 32] = $urandom;
          if (m == 1) rw[c*N +: N] = rx;
          else if (m == 2) rw[c*N +: N] = ~rx;
          else if (m == 3) rw[c*N +: N] = rx ^ (rw[c*N +: N] & {N/32{32'($urandom)}} & {N/32{32'($urandom)}});
          rt[c*W1 +: W1] = 16'($urandom_range(0, 1400));
        end
        beat(rx, rw, rt, b == 0 ? ($urandom % 8 != 0) : ($urandom % 16 == 0), b == nb - 1);
        if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) tick();
      end
    end
    rand_mode = 0;
    out_ready = 1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
    chk("drain_valid", 64'(out_valid), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
